// File: rtl/updown_limit_counter.sv
// Up/down counter with programmable inclusive limits, wrap or saturate at the
// boundary, synchronous load, one-cycle terminal pulse and sticky overflow flag.
module updown_limit_counter #(
    parameter int unsigned           WIDTH   = 4,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Clk_EN,
    input  logic             enable,
    input  logic             load,
    input  logic             up_down,
    input  logic             sat_mode,
    input  logic             clr_ovf,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] lo_limit,
    input  logic [WIDTH-1:0] hi_limit,
    output logic [WIDTH-1:0] count_out,
    output logic             co,
    output logic             at_limit,
    output logic             ovf
);

    logic [WIDTH-1:0] eff_lo;
    logic [WIDTH-1:0] eff_hi;
    logic             at_hi;
    logic             at_lo;
    logic             step;
    logic             bnd_step;
    logic [WIDTH-1:0] count_nxt;

    // Crossed limits fall back to the full WIDTH-bit range.
    always_comb begin
        if (lo_limit > hi_limit) begin
            eff_lo = '0;
            eff_hi = '1;
        end else begin
            eff_lo = lo_limit;
            eff_hi = hi_limit;
        end
    end

    assign at_hi    = (count_out >= eff_hi);
    assign at_lo    = (count_out <= eff_lo);
    assign at_limit = up_down ? at_hi : at_lo;
    assign step     = enable & Clk_EN;
    assign bnd_step = ~load & step & at_limit;

    // +1 only below HI and -1 only above LO, so neither can roll over.
    always_comb begin
        count_nxt = count_out;
        if (up_down) begin
            if (!at_hi)
                count_nxt = count_out + 1'b1;
            else
                count_nxt = sat_mode ? eff_hi : eff_lo;
        end else begin
            if (!at_lo)
                count_nxt = count_out - 1'b1;
            else
                count_nxt = sat_mode ? eff_lo : eff_hi;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_out <= RST_VAL;
            co        <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (load)
                count_out <= data_in;
            else if (step)
                count_out <= count_nxt;
            co <= bnd_step;
            if (bnd_step)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_limit_counter.sv
// Directed self-checking bench for updown_limit_counter (WIDTH=4, RST_VAL=0).
module tb_updown_limit_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       Clk_EN, enable, load, up_down, sat_mode, clr_ovf;
    logic [3:0] data_in, lo_limit, hi_limit;
    logic [3:0] count_out;
    logic       co, at_limit, ovf;

    int tests = 0;
    int fails = 0;

    updown_limit_counter #(.WIDTH(4), .RST_VAL(4'd0)) dut (
        .clk(clk), .rst(rst), .Clk_EN(Clk_EN), .enable(enable), .load(load),
        .up_down(up_down), .sat_mode(sat_mode), .clr_ovf(clr_ovf),
        .data_in(data_in), .lo_limit(lo_limit), .hi_limit(hi_limit),
        .count_out(count_out), .co(co), .at_limit(at_limit), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs sampled 1 ns after the edge; expected values are hand-computed.
    task automatic test_reset();
        rst = 1'b1; Clk_EN = 1'b1; enable = 1'b0; load = 1'b0; up_down = 1'b1;
        sat_mode = 1'b0; clr_ovf = 1'b0; data_in = '0; lo_limit = 4'd0; hi_limit = 4'd15;
        #12;
        tests++;
        if (count_out !== 4'd0 || co !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset: count=%0d co=%b ovf=%b, want count=0 co=0 ovf=0", count_out, co, ovf);
        end
    endtask

    task automatic test_basic_up();
        logic [3:0] exp;
        @(negedge clk);
        rst = 1'b0; enable = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            exp = 4'(i % 16);
            tests++;
            if (count_out !== exp || co !== (i == 16) || ovf !== (i >= 16)) begin
                fails++;
                $display("FAIL basic_up[%0d]: count=%0d co=%b ovf=%b, want count=%0d co=%b ovf=%b",
                         i, count_out, co, ovf, exp, (i == 16), (i >= 16));
            end
        end
        tick(); // count=2
        #2 rst = 1'b1;
        #1;
        tests++;
        if (count_out !== 4'd0 || co !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: count=%0d co=%b ovf=%b, want 0 0 0", count_out, co, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        tests++;
        if (count_out !== 4'd1) begin
            fails++;
            $display("FAIL first_step_after_reset: count=%0d, want 1", count_out);
        end
    endtask

    task automatic test_modulus_wrap();
        lo_limit = 4'd3; hi_limit = 4'd9; sat_mode = 1'b0;
        enable = 1'b0; load = 1'b1; data_in = 4'd3;
        tick();
        load = 1'b0; enable = 1'b1; up_down = 1'b0;
        tick();
        tests++;
        if (count_out !== 4'd9 || co !== 1'b1) begin
            fails++;
            $display("FAIL wrap_down: count=%0d co=%b, want 9 1", count_out, co);
        end
        load = 1'b1; data_in = 4'd8; enable = 1'b0; up_down = 1'b1;
        tick();
        load = 1'b0; enable = 1'b1;
        #1;
        tests++;
        if (at_limit !== 1'b0) begin
            fails++;
            $display("FAIL at_limit_8: at_limit=%b, want 0", at_limit);
        end
        tick();
        tests++;
        if (count_out !== 4'd9 || co !== 1'b0 || at_limit !== 1'b1) begin
            fails++;
            $display("FAIL up_to_9: count=%0d co=%b at_limit=%b, want 9 0 1", count_out, co, at_limit);
        end
        tick();
        tests++;
        if (count_out !== 4'd3 || co !== 1'b1) begin
            fails++;
            $display("FAIL wrap_up: count=%0d co=%b, want 3 1", count_out, co);
        end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_up [3] = '{4'd5, 4'd5, 4'd5};
        logic       co_up  [3] = '{1'b0, 1'b1, 1'b1};
        lo_limit = 4'd2; hi_limit = 4'd5; sat_mode = 1'b1;
        load = 1'b1; data_in = 4'd4; up_down = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (count_out !== exp_up[i] || co !== co_up[i]) begin
                fails++;
                $display("FAIL sat_up[%0d]: count=%0d co=%b, want %0d %b", i, count_out, co, exp_up[i], co_up[i]);
            end
        end
        load = 1'b1; data_in = 4'd3; up_down = 1'b0;
        tick();
        load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (count_out !== 4'd2 || co !== (i == 1)) begin
                fails++;
                $display("FAIL sat_down[%0d]: count=%0d co=%b, want 2 %b", i, count_out, co, (i == 1));
            end
        end
        sat_mode = 1'b0;
    endtask

    task automatic test_load_priority();
        lo_limit = 4'd0; hi_limit = 4'd15; up_down = 1'b1; enable = 1'b1; Clk_EN = 1'b1;
        load = 1'b1; data_in = 4'd12;
        tick();
        tests++;
        if (count_out !== 4'd12 || co !== 1'b0) begin
            fails++;
            $display("FAIL load_over_step: count=%0d co=%b, want 12 0", count_out, co);
        end
        load = 1'b0; Clk_EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (count_out !== 4'd12 || co !== 1'b0) begin
                fails++;
                $display("FAIL clk_en_hold[%0d]: count=%0d co=%b, want 12 0", i, count_out, co);
            end
        end
        Clk_EN = 1'b1; lo_limit = 4'd3; hi_limit = 4'd9;
        load = 1'b1; data_in = 4'd14;
        tick();
        tests++;
        if (count_out !== 4'd14) begin
            fails++;
            $display("FAIL load_out_of_range: count=%0d, want 14", count_out);
        end
        load = 1'b0;
        tick();
        tests++;
        if (count_out !== 4'd3 || co !== 1'b1) begin
            fails++;
            $display("FAIL above_hi_step: count=%0d co=%b, want 3 1", count_out, co);
        end
    endtask

    task automatic test_sticky_ovf();
        lo_limit = 4'd0; hi_limit = 4'd15; up_down = 1'b1;
        enable = 1'b0; clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0; load = 1'b1; data_in = 4'd15;
        tick();
        load = 1'b0; enable = 1'b1;
        tick();
        tests++;
        if (ovf !== 1'b1 || count_out !== 4'd0) begin
            fails++;
            $display("FAIL ovf_set: ovf=%b count=%0d, want 1 0", ovf, count_out);
        end
        enable = 1'b0; clr_ovf = 1'b1;
        tick();
        tests++;
        if (ovf !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: ovf=%b, want 0", ovf);
        end
        clr_ovf = 1'b0; load = 1'b1; data_in = 4'd15;
        tick();
        load = 1'b0; enable = 1'b1; clr_ovf = 1'b1;
        tick();
        tests++;
        if (ovf !== 1'b1 || co !== 1'b1 || count_out !== 4'd0) begin
            fails++;
            $display("FAIL ovf_set_wins: ovf=%b co=%b count=%0d, want 1 1 0", ovf, co, count_out);
        end
        clr_ovf = 1'b0; enable = 1'b0;
    endtask

    task automatic test_invalid_limits();
        lo_limit = 4'd10; hi_limit = 4'd4; up_down = 1'b1;
        load = 1'b1; data_in = 4'd15;
        tick();
        load = 1'b0; enable = 1'b1;
        #1;
        tests++;
        if (at_limit !== 1'b1) begin
            fails++;
            $display("FAIL inv_at_limit_15: at_limit=%b, want 1", at_limit);
        end
        tick();
        tests++;
        if (count_out !== 4'd0 || co !== 1'b1) begin
            fails++;
            $display("FAIL inv_wrap_up: count=%0d co=%b, want 0 1", count_out, co);
        end
        enable = 1'b0; up_down = 1'b0;
        #1;
        tests++;
        if (at_limit !== 1'b1) begin
            fails++;
            $display("FAIL inv_at_limit_0: at_limit=%b, want 1", at_limit);
        end
        enable = 1'b1;
        tick();
        tests++;
        if (count_out !== 4'd15 || co !== 1'b1) begin
            fails++;
            $display("FAIL inv_wrap_down: count=%0d co=%b, want 15 1", count_out, co);
        end
        enable = 1'b0;
        tick();
        tests++;
        if (co !== 1'b0 || count_out !== 4'd15) begin
            fails++;
            $display("FAIL co_one_cycle: co=%b count=%0d, want 0 15", co, count_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic_up();
        test_modulus_wrap();
        test_saturate();
        test_load_priority();
        test_sticky_ovf();
        test_invalid_limits();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/updown_limit_counter.md
# updown_limit_counter

Parametrised up/down counter with programmable lower/upper limits, a selectable wrap or saturate mode, a registered synchronous load, a registered terminal-count pulse and a sticky overflow flag. It is the next generation of the lab's basic up/down counter. It sits behind the board clock-enable divider (`Clk_EN`) and drives 7-segment/LED displays and event timers that need a modulus other than 2^WIDTH.

## Interface
Parameters:
- `WIDTH`, 4, counter width in bits (≥2)
- `RST_VAL`, 0, value of `count_out` after reset

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `Clk_EN`  in  1  clock-enable tick from the divider; a count step happens only on cycles where it is 1
- `enable`  in  1  count enable
- `load`  in  1  synchronous load request
- `up_down`  in  1  1 = count up, 0 = count down
- `sat_mode`  in  1  1 = saturate at limit, 0 = wrap to the opposite limit
- `clr_ovf`  in  1  synchronous clear of `ovf`
- `data_in`  in  WIDTH  load value
- `lo_limit`  in  WIDTH  lower bound (inclusive)
- `hi_limit`  in  WIDTH  upper bound (inclusive)
- `count_out`  out  WIDTH  registered count
- `co`  out  1  registered terminal pulse, one cycle wide
- `at_limit`  out  1  combinational: count sits at the limit in the current direction
- `ovf`  out  1  sticky flag: a boundary step has occurred

## Operation
- Reset (`rst`=1, asynchronous): `count_out`=RST_VAL, `co`=0, `ovf`=0. This takes effect immediately, including mid-count or mid-load.
- Effective bounds: if `lo_limit` > `hi_limit`, then LO=0 and HI=2^WIDTH−1. Otherwise LO=`lo_limit` and HI=`hi_limit`.
- Each rising edge is evaluated in priority order:
  1. `load`=1: `count_out`←`data_in`, loaded even if outside [LO,HI]. No step occurs and `co`←0. Load does not depend on `enable` or `Clk_EN`.
  2. step = `enable` & `Clk_EN`:
     - Up, `count_out` < HI: count+1.
     - Up, `count_out` ≥ HI (boundary): wrap mode →LO; sat mode →HI.
     - Down, `count_out` > LO: count−1.
     - Down, `count_out` ≤ LO (boundary): wrap mode →HI; sat mode →LO.
  3. No load and no step: hold the count; `co`←0.
- An out-of-range value therefore resolves on its first step. Example: up with count > HI returns to LO or HI; it never walks past 2^WIDTH−1.
- `co`←1 on a boundary step only, in both modes, including saturate-hold. Otherwise `co`←0. `co` is never high on two consecutive cycles unless two consecutive boundary steps occur.
- `ovf` is set on any boundary step. It is cleared by `clr_ovf` when there is no boundary step in the same cycle. If set and clear coincide, set wins.
- `at_limit` = `up_down` ? (`count_out` ≥ HI) : (`count_out` ≤ LO). It updates combinationally with `up_down` and the limits.
- All arithmetic is WIDTH-bit unsigned. The +1/−1 results never rely on natural modulo wrap.

## Timing
- Load and step latency: 1 cycle. `count_out` reflects the new value after the capturing edge.
- `co` and `ovf` are asserted in the same edge that performs the boundary step, aligned with the wrapped/held `count_out`.
- `at_limit` has zero latency (combinational from registers and inputs).
- Changing `sat_mode`, `up_down` or the limits takes effect at the next edge. There are no internal pipeline stages.
- Reset release: the first step can occur on the first rising edge after `rst` falls.

## Test plan
- Reset/basic up: WIDTH=4, lo=0, hi=15, wrap, `enable`=`Clk_EN`=1, up for 17 cycles → 0,1,…,15,0,1. `co` and `ovf` go high in the cycle count becomes 0. `rst` pulsed mid-run → count=0, `co`=0, `ovf`=0 immediately.
- Modulus wrap both directions: lo=3, hi=9, load 3. Down 1 step → 9 with `co`=1. Up from 8 → 9 (`at_limit`=1), then → 3 with `co`=1.
- Saturate: lo=2, hi=5, `sat_mode`=1, up from 4 → 5,5,5 with `co`=1 on each held step. Down from 3 → 2,2 with `co`=1 on the held step.
- Load priority/gating: `load`=1 with `data_in`=12 and `enable`=1 on the same edge → 12, `co`=0. `Clk_EN`=0 for 5 cycles → count holds. Load 14 with hi=9 then step up → 3 (wrap to lo), `co`=1.
- Sticky flag: trigger a boundary step → `ovf`=1. `clr_ovf` with no step → `ovf`=0. `clr_ovf` coinciding with a boundary step → `ovf` stays 1.
- Invalid limits: lo=10, hi=4, up from 15 → 0 with `co`=1. Down from 0 → 15.
